// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between a BCD source and the bcd_to_bin converter.
interface bcd_to_bin_if #(
   parameter int N = 10
);
   logic         start;
   logic [3:0]   bcd_cen;
   logic [3:0]   bcd_dec;
   logic [3:0]   bcd_uni;
   logic [N-1:0] binary;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output start, bcd_cen, bcd_dec, bcd_uni,
      input  binary, busy, done, err
   );

   modport slave (
      input  start, bcd_cen, bcd_dec, bcd_uni,
      output binary, busy, done, err
   );
endinterface

// File: rtl/bcd_to_bin.sv
// Three-digit BCD to binary converter using reverse double-dabble,
// one shift/correct iteration per clock.
//
// state | meaning
// IDLE  | waiting for start; a rejected request pulses done/err one cycle later
// SHIFT | N iterations of shift-right and subtract-3 correction
module bcd_to_bin #(
   parameter int N = 10
) (
   input  logic      clk,
   input  logic      rst_n,
   bcd_to_bin_if.slave bus
);

   localparam int CW = $clog2(N);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state, state_n;
   logic [11:0]   bcd_q, bcd_n, bcd_s;
   logic [N-1:0]  sh_q, sh_n, sh_s;
   logic [N-1:0]  bin_q, bin_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          done_q, done_n;
   logic          err_q, err_n;
   logic          rej_q, rej_n;
   logic          digits_ok;

   assign digits_ok = (bus.bcd_cen <= 4'd9) && (bus.bcd_dec <= 4'd9) &&
                      (bus.bcd_uni <= 4'd9);

   // One iteration: shift {bcd, sh} right, then correct nibbles that reached 8 or more.
   always_comb begin
      bcd_s = {1'b0, bcd_q[11:1]};
      sh_s  = {bcd_q[0], sh_q[N-1:1]};
      for (int i = 0; i < 3; i++) begin
         if (bcd_s[i*4 +: 4] >= 4'd8)
            bcd_s[i*4 +: 4] = bcd_s[i*4 +: 4] - 4'd3;
      end
   end

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         bcd_q  <= '0;
         sh_q   <= '0;
         bin_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         rej_q  <= 1'b0;
      end else begin
         state  <= state_n;
         bcd_q  <= bcd_n;
         sh_q   <= sh_n;
         bin_q  <= bin_n;
         cnt_q  <= cnt_n;
         done_q <= done_n;
         err_q  <= err_n;
         rej_q  <= rej_n;
      end
   end

   // Next-state and next-register values.
   always_comb begin
      state_n = state;
      bcd_n   = bcd_q;
      sh_n    = sh_q;
      bin_n   = bin_q;
      cnt_n   = cnt_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      rej_n   = 1'b0;

      // A rejection is reported one edge after the start that caused it.
      if (rej_q) begin
         done_n = 1'b1;
         err_n  = 1'b1;
      end

      case (state)
         IDLE: begin
            if (bus.start) begin
               if (digits_ok) begin
                  bcd_n   = {bus.bcd_cen, bus.bcd_dec, bus.bcd_uni};
                  sh_n    = '0;
                  cnt_n   = '0;
                  state_n = SHIFT;
               end else begin
                  rej_n = 1'b1;
               end
            end
         end
         SHIFT: begin
            bcd_n = bcd_s;
            sh_n  = sh_s;
            cnt_n = cnt_q + 1'b1;
            if (cnt_q == CW'(N-1)) begin
               bin_n   = sh_s;
               done_n  = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.binary = bin_q;
   assign bus.busy   = (state == SHIFT);
   assign bus.done   = done_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: N=10 instance for the main behaviour,
// N=12 instance for the zero-extended wide result.
module tb_bcd_to_bin;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   bcd_to_bin_if #(.N(10)) bus ();
   bcd_to_bin_if #(.N(12)) bus12 ();

   bcd_to_bin #(.N(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   bcd_to_bin #(.N(12)) dut12 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus12.slave)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
      @(negedge clk);
      bus.bcd_cen = c;
      bus.bcd_dec = d;
      bus.bcd_uni = u;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Called #1 after the accepting edge; returns edges until done is seen.
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!bus.done && cyc < 40);
      if (!bus.done) check_val("done_timeout", 0, 1);
   endtask

   task automatic run10(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                        input int exp, input string tag);
      int cyc;
      apply(c, d, u);
      check_val({tag, "_busy"}, 32'(bus.busy), 1);
      wait_done(cyc);
      check_val({tag, "_lat"}, cyc, 10);
      check_val({tag, "_bin"}, 32'(bus.binary), exp);
      check_val({tag, "_err"}, 32'(bus.err), 0);
      check_val({tag, "_busy_done"}, 32'(bus.busy), 0);
      @(posedge clk);
      #1;
      check_val({tag, "_done_pulse"}, 32'(bus.done), 0);
   endtask

   initial begin
      int cyc;
      int ndone;
      int done_at;
      logic [3:0] rc [3];
      logic [3:0] rd [3];
      logic [3:0] ru [3];

      bus.start = 1'b0;
      bus.bcd_cen = '0;
      bus.bcd_dec = '0;
      bus.bcd_uni = '0;
      bus12.start = 1'b0;
      bus12.bcd_cen = '0;
      bus12.bcd_dec = '0;
      bus12.bcd_uni = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("rst_binary", 32'(bus.binary), 0);
      check_val("rst_busy", 32'(bus.busy), 0);
      check_val("rst_done", 32'(bus.done), 0);
      check_val("rst_err", 32'(bus.err), 0);

      run10(4'd1, 4'd2, 4'd3, 123, "c123");
      run10(4'd9, 4'd9, 4'd9, 999, "c999");

      // Back-to-back: start 0,0,0 in the done cycle of a 9,9,9 run.
      apply(4'd9, 4'd9, 4'd9);
      wait_done(cyc);
      check_val("b2b_first", 32'(bus.binary), 999);
      bus.bcd_cen = 4'd0;
      bus.bcd_dec = 4'd0;
      bus.bcd_uni = 4'd0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_val("b2b_busy", 32'(bus.busy), 1);
      wait_done(cyc);
      check_val("b2b_lat", cyc, 10);
      check_val("b2b_zero", 32'(bus.binary), 0);

      // Rejections after a valid 456.
      run10(4'd4, 4'd5, 4'd6, 456, "c456");
      rc[0] = 4'd4; rd[0] = 4'hA; ru[0] = 4'd6;
      rc[1] = 4'd4; rd[1] = 4'd5; ru[1] = 4'hF;
      rc[2] = 4'hC; rd[2] = 4'd5; ru[2] = 4'd6;
      for (int k = 0; k < 3; k++) begin
         apply(rc[k], rd[k], ru[k]);
         check_val("rej_e0_done", 32'(bus.done), 0);
         check_val("rej_e0_busy", 32'(bus.busy), 0);
         @(posedge clk);
         #1;
         check_val("rej_done", 32'(bus.done), 1);
         check_val("rej_err", 32'(bus.err), 1);
         check_val("rej_busy", 32'(bus.busy), 0);
         check_val("rej_bin", 32'(bus.binary), 456);
         @(posedge clk);
         #1;
         check_val("rej_done_off", 32'(bus.done), 0);
         check_val("rej_err_off", 32'(bus.err), 0);
      end

      // Start pulse during SHIFT is ignored.
      apply(4'd7, 4'd0, 4'd5);
      ndone = 0;
      done_at = 0;
      for (int t = 1; t <= 16; t++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            done_at = t;
         end
         if (t == 4) begin
            bus.bcd_cen = 4'd3;
            bus.bcd_dec = 4'd3;
            bus.bcd_uni = 4'd3;
            bus.start = 1'b1;
         end
         if (t == 5) bus.start = 1'b0;
      end
      check_val("ign_ndone", ndone, 1);
      check_val("ign_at", done_at, 10);
      check_val("ign_bin", 32'(bus.binary), 705);

      // Asynchronous reset mid-conversion.
      apply(4'd9, 4'd1, 4'd2);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mrst_bin", 32'(bus.binary), 0);
      check_val("mrst_busy", 32'(bus.busy), 0);
      check_val("mrst_done", 32'(bus.done), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int t = 0; t < 15; t++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check_val("mrst_nodone", ndone, 0);
      check_val("mrst_idle", 32'(bus.busy), 0);
      run10(4'd0, 4'd4, 4'd2, 42, "c042");

      // Wide instance: 888 and 999 after 12 iterations.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus12.bcd_cen = (k == 0) ? 4'd8 : 4'd9;
         bus12.bcd_dec = (k == 0) ? 4'd8 : 4'd9;
         bus12.bcd_uni = (k == 0) ? 4'd8 : 4'd9;
         bus12.start = 1'b1;
         @(posedge clk);
         #1;
         bus12.start = 1'b0;
         check_val("n12_busy", 32'(bus12.busy), 1);
         cyc = 0;
         do begin
            @(posedge clk);
            #1;
            cyc++;
         end while (!bus12.done && cyc < 40);
         check_val("n12_lat", cyc, 12);
         check_val("n12_bin", 32'(bus12.binary), (k == 0) ? 888 : 999);
         check_val("n12_err", 32'(bus12.err), 0);
      end

      // Exhaustive sweep with start held high back-to-back.
      @(negedge clk);
      bus.start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         for (int d = 0; d < 10; d++) begin
            for (int u = 0; u < 10; u++) begin
               bus.bcd_cen = 4'(c);
               bus.bcd_dec = 4'(d);
               bus.bcd_uni = 4'(u);
               @(posedge clk);
               #1;
               check_val("sw_busy", 32'(bus.busy), 1);
               wait_done(cyc);
               check_val("sw_lat", cyc, 10);
               check_val("sw_bin", 32'(bus.binary), c * 100 + d * 10 + u);
            end
         end
      end
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check_val("sw_end_idle", 32'(bus.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
